// File: rtl/icache_pkg.sv
// Shared types and sizing helpers for the icache line-fill controller.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DRAIN} fill_state_t;

  // Byte-offset bits inside one cache line of b words of word_w bits.
  function automatic int line_off_bits(input int b, input int word_w);
    return $clog2(b * word_w / 8);
  endfunction

  localparam int DEF_B      = 4;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_ADDR_W = 32;

endpackage

// File: rtl/icache_fill_ctlr_if.sv
// Miss / memory-beat / line-fill signal bundle between the icache, the fill controller and memory.
interface icache_fill_ctlr_if #(
  parameter int B      = 4,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic                  miss_i;
  logic [ADDR_W-1:0]     miss_addr_i;
  logic                  flush_i;
  logic                  mem_req_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [WORD_W-1:0]     mem_rdata_i;
  logic                  fill_we_o;
  logic [ADDR_W-1:0]     fill_addr_o;
  logic [B*WORD_W-1:0]   fill_data_o;
  logic                  busy_o;

  modport slave (
    input  miss_i, miss_addr_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, fill_we_o, fill_addr_o, fill_data_o, busy_o
  );

  modport master (
    output miss_i, miss_addr_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, fill_we_o, fill_addr_o, fill_data_o, busy_o
  );
endinterface

// File: rtl/icache_line_buf.sv
// B x WORD_W line assembly buffer; one word written per response beat.
module icache_line_buf #(
  parameter int B      = 4,
  parameter int WORD_W = 32,
  localparam int IDX_W = $clog2(B)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       we,
  input  logic [IDX_W-1:0]           idx,
  input  logic [WORD_W-1:0]          wdata,
  output logic [B-1:0][WORD_W-1:0]   line
);
  logic [B-1:0][WORD_W-1:0] words_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      words_q <= '0;
    end else if (we) begin
      for (int k = 0; k < B; k++)
        if (idx == IDX_W'(k)) words_q[k] <= wdata;
    end
  end

  assign line = words_q;
endmodule

// File: rtl/icache_fill_ctlr.sv
// Fetches one icache line beat-by-beat on a miss, then writes it with a one-cycle strobe.
// A flush abandons the fill and drains whatever beats are still in flight.
module icache_fill_ctlr
  import icache_pkg::*;
#(
  parameter int B      = DEF_B,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clk_i,
  input  logic            reset_i,
  icache_fill_ctlr_if.slave bus
);
  localparam int CNT_W = $clog2(B) + 1;
  localparam int IDX_W = $clog2(B);
  localparam int OFF_W = line_off_bits(B, WORD_W);
  localparam int BPW   = WORD_W / 8;
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(B);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  fill_state_t            state_q, state_d;
  logic [CNT_W-1:0]       req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic                   mem_req, req_fire, rsp_fire, buf_we;
  logic [B-1:0][WORD_W-1:0] line;

  // Request is decoded purely from registered state so gnt never feeds back into req.
  assign mem_req  = (state_q == REQ) && (req_cnt_q < LAST);
  assign req_fire = mem_req & bus.mem_gnt_i;
  // A beat is only accepted when one is owed; stray rvalids are dropped.
  assign rsp_fire = bus.mem_rvalid_i & (rsp_cnt_q != req_cnt_q) &
                    ((state_q == REQ) || (state_q == DRAIN));
  assign buf_we   = rsp_fire & (state_q == REQ);

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    base_d    = base_q;
    if (req_fire) req_cnt_d = req_cnt_q + 1'b1;
    if (rsp_fire) rsp_cnt_d = rsp_cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.miss_i && !bus.flush_i) begin
          state_d = REQ;
          base_d  = bus.miss_addr_i & ~OFF_MASK;
        end
      end
      REQ: begin
        if (bus.flush_i)
          state_d = DRAIN;
        else if (rsp_fire && (rsp_cnt_q == LAST - 1'b1))
          state_d = FILL;
      end
      FILL: begin
        state_d   = IDLE;
        req_cnt_d = '0;
        rsp_cnt_d = '0;
      end
      DRAIN: begin
        if (rsp_cnt_q == req_cnt_q) begin
          state_d   = IDLE;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      base_q    <= base_d;
    end
  end

  icache_line_buf #(.B(B), .WORD_W(WORD_W)) u_line_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we      (buf_we),
    .idx     (rsp_cnt_q[IDX_W-1:0]),
    .wdata   (bus.mem_rdata_i),
    .line    (line)
  );

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_req ? base_q + ADDR_W'(req_cnt_q) * ADDR_W'(BPW) : '0;
  assign bus.fill_we_o   = (state_q == FILL);
  assign bus.fill_addr_o = base_q;
  assign bus.fill_data_o = line;
  assign bus.busy_o      = (state_q != IDLE);

  // Memory must never return more beats than were granted.
  rvalid_owed: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.mem_rvalid_i |-> (rsp_cnt_q != req_cnt_q));
endmodule

// File: tb/tb_icache_fill_ctlr.sv
// Directed bench for icache_fill_ctlr: memory model on the beat side, scoreboard on the fill side.
module tb_icache_fill_ctlr;
  localparam int B = 4, WORD_W = 32, ADDR_W = 32;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  icache_fill_ctlr_if #(.B(B), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();
  icache_fill_ctlr #(.B(B), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus));

  typedef struct { logic [ADDR_W-1:0] addr; logic [B*WORD_W-1:0] data; } line_t;
  typedef struct { logic [WORD_W-1:0] data; int due; } beat_t;

  line_t             sb[$];
  logic [ADDR_W-1:0] req_exp[$];
  beat_t             pend[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int gnt_mode = 0, gnt_budget = 0, rv_delay = 1, rv_cnt = 0, fill_cnt = 0;
  logic [WORD_W-1:0] salt = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a,
                                                 input logic [WORD_W-1:0] s);
    return (s ^ {a[ADDR_W-1:4], 4'h0}) | WORD_W'(a[3:2]);
  endfunction

  function automatic line_t exp_line(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] s);
    line_t l;
    l.addr = {a[ADDR_W-1:4], 4'h0};
    for (int k = 0; k < B; k++)
      l.data[k*WORD_W +: WORD_W] = mem_word(l.addr + ADDR_W'(4 * k), s);
    return l;
  endfunction

  always @(posedge clk_i) cyc++;

  // Memory: decides gnt/rvalid at negedge for the coming edge; responses in order.
  always @(negedge clk_i) begin
    if (reset_i) begin
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
      pend.delete();
    end else begin
      logic g;
      logic [ADDR_W-1:0] ea;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = pend[0].data;
        void'(pend.pop_front()); rv_cnt++;
      end else begin
        bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
      end
      case (gnt_mode)
        0:       g = 1'b1;
        1:       g = 1'($urandom_range(0, 1));
        default: g = (gnt_budget > 0);
      endcase
      bus.mem_gnt_i = g;
      if (bus.mem_req_o) chk("req_expected", req_exp.size() != 0, 1);
      if (g && bus.mem_req_o && req_exp.size() != 0) begin
        ea = req_exp.pop_front();
        chk("req_addr", bus.mem_addr_o, ea);
        pend.push_back('{data: mem_word(bus.mem_addr_o, salt),
                         due: cyc + ((rv_delay == 0) ? int'($urandom_range(1, 5)) : rv_delay)});
        if (gnt_mode == 2) gnt_budget--;
      end
    end
  end

  // Fill scoreboard.
  always @(negedge clk_i) begin
    if (!reset_i && bus.fill_we_o) begin
      line_t e;
      fill_cnt++;
      chk("fill_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("fill_addr", bus.fill_addr_o, e.addr);
        chk("fill_data", bus.fill_data_o, e.data);
      end
    end
  end

  task automatic tick();
    @(negedge clk_i); #1;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input bit want_fill);
    for (int k = 0; k < B; k++) req_exp.push_back({a[ADDR_W-1:4], 4'h0} + ADDR_W'(4 * k));
    if (want_fill) sb.push_back(exp_line(a, salt));
  endtask

  task automatic start_miss(input logic [ADDR_W-1:0] a, input bit want_fill);
    push_exp(a, want_fill);
    bus.miss_addr_i = a; bus.miss_i = 1'b1;
  endtask

  task automatic wait_fill(input string tag, output int at);
    bit seen;
    seen = 0; at = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (bus.fill_we_o) begin seen = 1; at = cyc; end
    end
    chk({tag, "_fill_seen"}, seen, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (!bus.busy_o && pend.size() == 0) done = 1;
    end
    chk({tag, "_idle"}, done, 1);
  endtask

  task automatic wait_rvalid(input string tag, input int nth);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (bus.mem_rvalid_i && rv_cnt == nth) seen = 1;
    end
    chk({tag, "_rvalid_seen"}, seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, c0, f0;
    bus.miss_i = 1'b0; bus.miss_addr_i = '0; bus.flush_i = 1'b0;
    repeat (3) tick();
    chk("rst_mem_req",   bus.mem_req_o, 0);
    chk("rst_mem_addr",  bus.mem_addr_o, 0);
    chk("rst_fill_we",   bus.fill_we_o, 0);
    chk("rst_fill_addr", bus.fill_addr_o, 0);
    chk("rst_fill_data", bus.fill_data_o, 0);
    chk("rst_busy",      bus.busy_o, 0);
    reset_i = 1'b0;
    tick();

    // 1: ideal memory, fixed latency and known data
    salt = 32'h10E0; gnt_mode = 0; rv_delay = 1;
    start_miss(32'h104C, 0);
    sb.push_back('{addr: 32'h1040, data: 128'h000000A3_000000A2_000000A1_000000A0});
    c0 = cyc;
    wait_fill("t1", at);
    chk("t1_latency", at - c0, B + 2);
    bus.miss_i = 1'b0;
    wait_idle("t1");

    // 2: random grant stalls and response delays
    gnt_mode = 1; rv_delay = 0;
    for (int n = 0; n < 3; n++) begin
      salt = $urandom & 32'hFFFF_FFF0;
      start_miss($urandom, 1);
      wait_fill("t2", at);
      bus.miss_i = 1'b0;
      wait_idle("t2");
    end

    // 3: flush after 2 grants / 1 response, then a fresh line
    gnt_mode = 2; gnt_budget = 2; rv_delay = 3; rv_cnt = 0; salt = 32'h3330;
    start_miss(32'h2000, 0);
    wait_rvalid("t3", 1);
    bus.flush_i = 1'b1; bus.miss_i = 1'b0;
    tick();
    bus.flush_i = 1'b0;
    chk("t3_drain_busy", bus.busy_o, 1);
    chk("t3_drain_noreq", bus.mem_req_o, 0);
    wait_idle("t3");
    chk("t3_rv_total", rv_cnt, 2);
    req_exp.delete();
    gnt_mode = 0; rv_delay = 1; salt = 32'h5550;
    start_miss(32'h3008, 1);
    wait_fill("t3b", at);
    bus.miss_i = 1'b0;
    wait_idle("t3b");

    // 4a: flush together with the last beat -> no fill
    rv_cnt = 0; salt = 32'h7770;
    start_miss(32'h4010, 0);
    wait_rvalid("t4", 4);
    bus.flush_i = 1'b1; bus.miss_i = 1'b0;
    tick();
    bus.flush_i = 1'b0;
    chk("t4_drain_busy", bus.busy_o, 1);
    chk("t4_no_fill_we", bus.fill_we_o, 0);
    wait_idle("t4");
    // 4b: flush during FILL does not cancel it
    start_miss(32'h5020, 1);
    wait_fill("t4b", at);
    bus.flush_i = 1'b1; bus.miss_i = 1'b0;
    tick();
    bus.flush_i = 1'b0;
    chk("t4b_idle_after_fill", bus.busy_o, 0);
    wait_idle("t4b");

    // 5a: miss held through FILL, dropped in IDLE -> one fill
    f0 = fill_cnt; salt = 32'h9990;
    start_miss(32'h6030, 1);
    wait_fill("t5", at);
    tick();
    chk("t5_idle_after_fill", bus.busy_o, 0);
    bus.miss_i = 1'b0;
    wait_idle("t5");
    chk("t5_one_fill", fill_cnt - f0, 1);
    // 5b: miss still high in IDLE -> second fill
    f0 = fill_cnt;
    start_miss(32'h7040, 1);
    push_exp(32'h7040, 1);
    wait_fill("t5b", at);
    tick();
    chk("t5b_idle", bus.busy_o, 0);
    tick();
    chk("t5b_retrigger", bus.busy_o, 1);
    bus.miss_i = 1'b0;
    wait_fill("t5b2", at);
    wait_idle("t5b");
    chk("t5b_two_fills", fill_cnt - f0, 2);

    // 6: async reset with two beats outstanding
    gnt_mode = 0; rv_delay = 5; salt = 32'hBBB0;
    start_miss(32'h8050, 0);
    repeat (3) tick();
    #1 reset_i = 1'b1;
    #1;
    chk("t6_mem_req", bus.mem_req_o, 0);
    chk("t6_mem_addr", bus.mem_addr_o, 0);
    chk("t6_fill_we", bus.fill_we_o, 0);
    chk("t6_busy", bus.busy_o, 0);
    bus.miss_i = 1'b0;
    req_exp.delete(); sb.delete();
    repeat (2) tick();
    reset_i = 1'b0;
    tick();
    rv_delay = 1; salt = 32'hCCC0;
    start_miss(32'h9064, 1);
    wait_fill("t6", at);
    bus.miss_i = 1'b0;
    wait_idle("t6");
    chk("end_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
